// File: rtl/barret_1481_sched.sv
// Shared scheduler in front of a single mod-1481 Barrett reducer: arbitrates NUM_REQ requesters into a
// two-stage pipeline (issue register S0, result register S1). Define BARRET_SCHED_RR_EN for round-robin; default is fixed priority.
`timescale 1ns/1ps

module barret_for_1481 (
    input  logic [20:0] din,
    output logic [10:0] dout
);
    // mu = floor(2^22 / 1481); for din < 2^21 the quotient estimate is short by at most one.
    localparam logic [32:0] MU = 33'd2832;

    logic [10:0] q;
    logic [20:0] qm;
    logic [11:0] r;

    always_comb begin
        q    = 11'(({12'd0, din} * MU) >> 22);
        qm   = {10'd0, q} * 21'd1481;
        r    = 12'(din - qm);
        dout = (r >= 12'd1481) ? 11'(r - 12'd1481) : r[10:0];
    end
endmodule

module barret_1481_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DIN_W   = 21,
    parameter int DOUT_W  = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DIN_W-1:0]   din_a,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [DOUT_W-1:0]          dout_r,
    output logic [1:0]                 in_flight,
    output logic                       idle
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // req_ready never depends combinationally on anything downstream except rsp_ready via s0_free.
    logic             s0_valid;
    logic [DIN_W-1:0] s0_data;
    logic [ID_W-1:0]  s0_id;
    logic [10:0]      red_out;

    logic             advance1;
    logic             s0_free;
    logic             grant_any;
    logic [ID_W-1:0]  grant_id;
    logic             take;

`ifdef BARRET_SCHED_RR_EN
    logic [ID_W-1:0]  rr_ptr;
`endif

    assign advance1 = s0_valid & (~rsp_valid | rsp_ready);
    assign s0_free  = ~s0_valid | advance1;
    assign take     = s0_free & grant_any;

    // Scan from highest to lowest candidate so the last hit is the winner.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
`ifdef BARRET_SCHED_RR_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            logic [ID_W:0] cand;
            cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ))
                cand = cand - (ID_W+1)'(NUM_REQ);
            if (req_valid[cand[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = cand[ID_W-1:0];
            end
        end
`else
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(i);
            end
        end
`endif
    end

    always_comb begin
        req_ready = '0;
        if (take)
            req_ready[grant_id] = 1'b1;
    end

    barret_for_1481 u_red (
        .din  (s0_data),
        .dout (red_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_data  <= '0;
            s0_id    <= '0;
        end else if (s0_free) begin
            s0_valid <= take;
            if (take) begin
                s0_data <= din_a[grant_id*DIN_W +: DIN_W];
                s0_id   <= grant_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            dout_r    <= '0;
            rsp_id    <= '0;
        end else if (advance1) begin
            rsp_valid <= 1'b1;
            dout_r    <= DOUT_W'(red_out);
            rsp_id    <= s0_id;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef BARRET_SCHED_RR_EN
    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (take)
            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
`endif

    assign in_flight = {1'b0, s0_valid} + {1'b0, rsp_valid};
    assign idle      = (in_flight == 2'd0) && !(|req_valid);
endmodule

// File: tb/tb_barret_1481_sched.sv
// Directed bench for barret_1481_sched: latency, throughput, arbitration order, backpressure,
// reset mid-operation and an operand sweep, checked against din % 1481 and a response queue.
`timescale 1ns/1ps

module tb_barret_1481_sched;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int DIN_W   = 21;
    localparam int DOUT_W  = 11;
    localparam int W       = ID_W + DOUT_W;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*DIN_W-1:0] din_a;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [DOUT_W-1:0]        dout_r;
    logic [1:0]               in_flight;
    logic                     idle;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];

    barret_1481_sched #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .DIN_W   (DIN_W),
        .DOUT_W  (DOUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .din_a     (din_a),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .dout_r    (dout_r),
        .in_flight (in_flight),
        .idle      (idle)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // checking
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic expect_rsp(input string tag);
        logic [W-1:0] e;
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_id"}, 32'(rsp_id), 32'(e[W-1:DOUT_W]));
            check({tag, "_dout"}, 32'(dout_r), 32'(e[DOUT_W-1:0]));
        end
    endtask

    // drivers
    task automatic set_op(input int id, input int op);
        din_a[id*DIN_W +: DIN_W] = DIN_W'(op);
    endtask

    task automatic push_exp(input int id, input int op);
        exp_q.push_back({ID_W'(id), DOUT_W'(op % 1481)});
    endtask

    task automatic single(input int id, input int op, input string tag);
        set_op(id, op);
        req_valid = NUM_REQ'(1 << id);
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(1 << id));
        push_exp(id, op);
        tick();
        req_valid = '0;
        check({tag, "_inflight1"}, 32'(in_flight), 32'd1);
        tick();
        expect_rsp(tag);
        tick();
        check({tag, "_drained"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int exp_g;
        int sweep_op;
        rst       = 1'b1;
        req_valid = '0;
        din_a     = '0;
        rsp_ready = 1'b1;
        do_reset();

        // reset state
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_dout", 32'(dout_r), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_in_flight", 32'(in_flight), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);

        // first request and full-scale operand
        single(2, 1481, "first");
        single(2, 2097151, "max_op");

        // back-to-back from requester 0
        set_op(0, 1480);
        req_valid = 4'b0001;
        #1;
        check("b2b_ready0", 32'(req_ready), 32'd1);
        push_exp(0, 1480);
        tick();
        set_op(0, 2962);
        check("b2b_inflight_a", 32'(in_flight), 32'd1);
        check("b2b_ready1", 32'(req_ready), 32'd1);
        push_exp(0, 2962);
        tick();
        set_op(0, 3000);
        expect_rsp("b2b_r0");
        check("b2b_inflight_b", 32'(in_flight), 32'd2);
        check("b2b_ready2", 32'(req_ready), 32'd1);
        push_exp(0, 3000);
        tick();
        req_valid = '0;
        expect_rsp("b2b_r1");
        check("b2b_inflight_c", 32'(in_flight), 32'd2);
        tick();
        expect_rsp("b2b_r2");
        check("b2b_inflight_d", 32'(in_flight), 32'd1);
        tick();
        check("b2b_empty", 32'(in_flight), 32'd0);

        // arbitration with all four requesters valid
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 100 + i);
        req_valid = 4'b1111;
        for (int step = 0; step < 6; step++) begin
`ifdef BARRET_SCHED_RR_EN
            exp_g = step % NUM_REQ;
`else
            exp_g = 0;
`endif
            #1;
            check("arb_grant", 32'(req_ready), 32'(1 << exp_g));
            push_exp(exp_g, 100 + exp_g);
            tick();
            if (step >= 1) expect_rsp("arb_rsp");
        end
        req_valid = '0;
        tick();
        expect_rsp("arb_last");
        tick();
        check("arb_drained", 32'(rsp_valid), 32'd0);

        // backpressure with three pending requests
        do_reset();
        rsp_ready = 1'b0;
        set_op(0, 5000);
        set_op(1, 7);
        set_op(3, 2000000);
        req_valid = 4'b1011;
        #1;
        check("bp_grant0", 32'(req_ready), 32'b0001);
        push_exp(0, 5000);
        tick();
        req_valid = 4'b1010;
        #1;
        check("bp_grant1", 32'(req_ready), 32'b0010);
        push_exp(1, 7);
        tick();
        req_valid = 4'b1000;
        #1;
        check("bp_full_ready", 32'(req_ready), 32'd0);
        check("bp_full_inflight", 32'(in_flight), 32'd2);
        tick();
        check("bp_hold_ready", 32'(req_ready), 32'd0);
        check("bp_hold_id", 32'(rsp_id), 32'd0);
        check("bp_hold_inflight", 32'(in_flight), 32'd2);
        rsp_ready = 1'b1;
        #1;
        check("bp_release_grant", 32'(req_ready), 32'b1000);
        push_exp(3, 2000000);
        expect_rsp("bp_r0");
        tick();
        req_valid = '0;
        expect_rsp("bp_r1");
        tick();
        expect_rsp("bp_r3");
        tick();
        check("bp_drained", 32'(rsp_valid), 32'd0);
        check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // reset with two operations in flight
        rsp_ready = 1'b0;
        set_op(2, 999);
        req_valid = 4'b0100;
        tick();
        tick();
        req_valid = '0;
        #1;
        check("mid_inflight", 32'(in_flight), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_in_flight", 32'(in_flight), 32'd0);
        check("mid_idle", 32'(idle), 32'd1);
        req_valid = 4'b1100;
        #1;
        check("mid_ptr_zero", 32'(req_ready), 32'b0100);
        req_valid = '0;
        rsp_ready = 1'b1;
        single(2, 12345, "after_rst");

        // operand sweep through requester 1
        single(1, 0, "sw_zero");
        single(1, 1, "sw_one");
        single(1, 1482, "sw_1482");
        single(1, 2961, "sw_2961");
        single(1, 2097150, "sw_maxm1");
        for (int k = 0; k < 40; k++) begin
            sweep_op = (k * 52429 + 1480) % 2097152;
            single(1, sweep_op, "sweep");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
